// File: rtl/sw_seq_loader.sv
// Framed word-stream loader for SW_core: parses a length header, packs 2-bit bases
// into left-aligned, tail-masked sequence vectors and hands them off via valid/ready.
module sw_seq_loader #(
  parameter int REF_MAX_LENGTH  = 256,
  parameter int READ_MAX_LENGTH = 128
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [31:0]                          i_word,
  input  logic                                 i_word_valid,
  output logic                                 o_word_ready,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [2*REF_MAX_LENGTH-1:0]          o_sequence_ref,
  output logic [2*READ_MAX_LENGTH-1:0]         o_sequence_read,
  output logic [$clog2(REF_MAX_LENGTH):0]      o_seq_ref_length,
  output logic [$clog2(READ_MAX_LENGTH):0]     o_seq_read_length,
  output logic                                 o_err
);

  localparam int REF_LEN_W  = $clog2(REF_MAX_LENGTH) + 1;
  localparam int READ_LEN_W = $clog2(READ_MAX_LENGTH) + 1;
  localparam int REF_W      = 2 * REF_MAX_LENGTH;
  localparam int READ_W     = 2 * READ_MAX_LENGTH;
  localparam int REF_WORDS  = REF_MAX_LENGTH / 16;
  localparam int READ_WORDS = READ_MAX_LENGTH / 16;
  localparam int CNT_W      = (REF_LEN_W > READ_LEN_W) ? REF_LEN_W : READ_LEN_W;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOAD_REF  = 2'd1;
  localparam logic [1:0] S_LOAD_READ = 2'd2;
  localparam logic [1:0] S_SEND      = 2'd3;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [REF_LEN_W-1:0]  r_ref_len;
  logic [READ_LEN_W-1:0] r_read_len;
  logic [REF_W-1:0]      r_seq_ref;
  logic [READ_W-1:0]     r_seq_read;
  logic                  r_valid;
  logic                  r_err;

  logic                  w_word_ready;
  logic                  w_xfer;
  logic [15:0]           w_hdr_ref;
  logic [15:0]           w_hdr_read;
  logic                  w_hdr_ok;
  logic [CNT_W-1:0]      w_ref_last_idx;
  logic [CNT_W-1:0]      w_read_last_idx;
  logic                  w_ref_last;
  logic                  w_read_last;
  logic [31:0]           w_word_masked;

  // Zero every base whose absolute index falls at or beyond the sequence length.
  function automatic logic [31:0] tail_mask(input logic [31:0] word, input int first_base,
                                            input int len);
    logic [31:0] m;
    m = word;
    for (int j = 0; j < 16; j++) begin
      m[31-2*j -: 2] = (first_base + j >= len) ? 2'b00 : word[31-2*j -: 2];
    end
    return m;
  endfunction

  assign w_word_ready    = (r_state != S_SEND);
  assign w_xfer          = i_word_valid && w_word_ready;
  assign w_hdr_ref       = i_word[31:16];
  assign w_hdr_read      = i_word[15:0];
  assign w_hdr_ok        = (w_hdr_ref != 16'd0) && (w_hdr_ref <= 16'(REF_MAX_LENGTH)) &&
                           (w_hdr_read != 16'd0) && (w_hdr_read <= 16'(READ_MAX_LENGTH));
  assign w_ref_last_idx  = CNT_W'((r_ref_len - REF_LEN_W'(1)) >> 4);
  assign w_read_last_idx = CNT_W'((r_read_len - READ_LEN_W'(1)) >> 4);
  assign w_ref_last      = (r_cnt == w_ref_last_idx);
  assign w_read_last     = (r_cnt == w_read_last_idx);

  // Select which sequence length governs masking of the incoming payload word.
  always_comb begin
    w_word_masked = 32'd0;
    if (r_state == S_LOAD_REF) begin
      w_word_masked = tail_mask(i_word, int'(r_cnt) * 16, int'(r_ref_len));
    end else begin
      w_word_masked = tail_mask(i_word, int'(r_cnt) * 16, int'(r_read_len));
    end
  end

  // Frame FSM: header check, word counting and core handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ref_len  <= '0;
      r_read_len <= '0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer && w_hdr_ok) begin
            r_ref_len  <= w_hdr_ref[REF_LEN_W-1:0];
            r_read_len <= w_hdr_read[READ_LEN_W-1:0];
            r_cnt      <= '0;
            r_state    <= S_LOAD_REF;
          end
        end
        S_LOAD_REF: begin
          if (w_xfer) begin
            if (w_ref_last) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_READ;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_LOAD_READ: begin
          if (w_xfer) begin
            if (w_read_last) begin
              r_cnt   <= '0;
              r_valid <= 1'b1;
              r_state <= S_SEND;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_SEND: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Sequence storage: cleared by a good header, then filled word by word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_ref  <= '0;
      r_seq_read <= '0;
    end else if (r_state == S_IDLE && w_xfer && w_hdr_ok) begin
      r_seq_ref  <= '0;
      r_seq_read <= '0;
    end else if (r_state == S_LOAD_REF && w_xfer) begin
      for (int k = 0; k < REF_WORDS; k++) begin
        if (r_cnt == CNT_W'(k)) r_seq_ref[REF_W-1-32*k -: 32] <= w_word_masked;
      end
    end else if (r_state == S_LOAD_READ && w_xfer) begin
      for (int k = 0; k < READ_WORDS; k++) begin
        if (r_cnt == CNT_W'(k)) r_seq_read[READ_W-1-32*k -: 32] <= w_word_masked;
      end
    end
  end

  // Single-cycle error pulse for a rejected header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && w_xfer && !w_hdr_ok;
    end
  end

  assign o_word_ready      = w_word_ready;
  assign o_valid           = r_valid;
  assign o_err             = r_err;
  assign o_sequence_ref    = r_seq_ref;
  assign o_sequence_read   = r_seq_read;
  assign o_seq_ref_length  = r_ref_len;
  assign o_seq_read_length = r_read_len;

endmodule

// File: tb/tb_sw_seq_loader.sv
// Directed bench for sw_seq_loader: frames are built here and expected vectors are
// rebuilt base-by-base from the payload words.
module tb_sw_seq_loader;

  localparam int REF_MAX  = 256;
  localparam int READ_MAX = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  i_word = 32'd0;
  logic         i_word_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic         o_word_ready;
  logic         o_valid;
  logic         o_err;
  logic [511:0] o_sequence_ref;
  logic [255:0] o_sequence_read;
  logic [8:0]   o_seq_ref_length;
  logic [7:0]   o_seq_read_length;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] ref_w [16];
  logic [31:0] read_w [8];
  logic [511:0] ref_snap;

  sw_seq_loader #(.REF_MAX_LENGTH(REF_MAX), .READ_MAX_LENGTH(READ_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .i_word(i_word), .i_word_valid(i_word_valid),
    .o_word_ready(o_word_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_sequence_ref(o_sequence_ref), .o_sequence_read(o_sequence_read),
    .o_seq_ref_length(o_seq_ref_length), .o_seq_read_length(o_seq_read_length),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_seq(input bit is_ref, input int len);
    logic [511:0] v;
    logic [31:0]  w;
    int           maxb;
    v = '0;
    maxb = is_ref ? REF_MAX : READ_MAX;
    for (int i = 0; i < len; i++) begin
      w = is_ref ? ref_w[i/16] : read_w[i/16];
      v[2*maxb-1-2*i -: 2] = w[31-2*(i%16) -: 2];
    end
    return v;
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < 16; k++) ref_w[k] = $urandom;
    for (int k = 0; k < 8; k++) read_w[k] = $urandom;
  endtask

  task automatic fill_const(input logic [31:0] w);
    for (int k = 0; k < 16; k++) ref_w[k] = w;
    for (int k = 0; k < 8; k++) read_w[k] = w;
  endtask

  task automatic put_word(input logic [31:0] w, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    t = 0;
    while (!o_word_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk_val("word_ready", {511'd0, o_word_ready}, 512'd1);
    i_word = w;
    i_word_valid = 1'b1;
    @(posedge clk);
    #1 i_word_valid = 1'b0;
  endtask

  task automatic load_frame(input int rl, input int dl, input int gapmax);
    put_word({16'(rl), 16'(dl)}, $urandom_range(gapmax, 0));
    for (int k = 0; k < (rl + 15) / 16; k++) put_word(ref_w[k], $urandom_range(gapmax, 0));
    for (int k = 0; k < (dl + 15) / 16; k++) put_word(read_w[k], $urandom_range(gapmax, 0));
  endtask

  task automatic check_out(input string tag, input int rl, input int dl);
    chk_val({tag, "_valid"}, {511'd0, o_valid}, 512'd1);
    chk_val({tag, "_wready"}, {511'd0, o_word_ready}, 512'd0);
    chk_val({tag, "_err"}, {511'd0, o_err}, 512'd0);
    chk_val({tag, "_ref"}, o_sequence_ref, exp_seq(1'b1, rl));
    chk_val({tag, "_read"}, {256'd0, o_sequence_read}, exp_seq(1'b0, dl));
    chk_val({tag, "_rlen"}, {503'd0, o_seq_ref_length}, 512'(rl));
    chk_val({tag, "_dlen"}, {504'd0, o_seq_read_length}, 512'(dl));
  endtask

  task automatic finish_hs(input string tag, input int rl);
    @(posedge clk);
    #1;
    chk_val({tag, "_vdrop"}, {511'd0, o_valid}, 512'd0);
    chk_val({tag, "_idle"}, {511'd0, o_word_ready}, 512'd1);
    chk_val({tag, "_hold"}, o_sequence_ref, exp_seq(1'b1, rl));
  endtask

  initial begin
    int rl;
    int dl;
    // Reset state
    repeat (3) @(negedge clk);
    chk_val("rst_valid", {511'd0, o_valid}, 512'd0);
    chk_val("rst_err", {511'd0, o_err}, 512'd0);
    chk_val("rst_wready", {511'd0, o_word_ready}, 512'd1);
    chk_val("rst_ref", o_sequence_ref, 512'd0);
    chk_val("rst_len", {495'd0, o_seq_ref_length, o_seq_read_length}, 512'd0);
    rst_n = 1'b1;

    // Full-length frame 128/128
    fill_rand();
    load_frame(128, 128, 0);
    check_out("full", 128, 128);
    chk_val("full_lowref", {256'd0, o_sequence_ref[255:0]}, 512'd0);
    finish_hs("full", 128);

    // Short lengths, all-ones payload: hand-computed masks
    fill_const(32'hFFFF_FFFF);
    load_frame(20, 5, 0);
    check_out("mask", 20, 5);
    chk_val("mask_ref_hand", o_sequence_ref, {{40{1'b1}}, {472{1'b0}}});
    chk_val("mask_read_hand", {256'd0, o_sequence_read}, {256'd0, {10{1'b1}}, {246{1'b0}}});
    finish_hs("mask", 20);

    // Core backpressure in SEND
    i_ready = 1'b0;
    fill_rand();
    load_frame(33, 17, 1);
    check_out("bp", 33, 17);
    ref_snap = o_sequence_ref;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk_val("bp_valid", {511'd0, o_valid}, 512'd1);
      chk_val("bp_wready", {511'd0, o_word_ready}, 512'd0);
      chk_val("bp_stable", o_sequence_ref, ref_snap);
    end
    @(negedge clk);
    i_ready = 1'b1;
    finish_hs("bp", 33);

    // Bad headers then a good frame
    put_word(32'h0000_0010, 0);
    chk_val("bad0_err", {511'd0, o_err}, 512'd1);
    chk_val("bad0_valid", {511'd0, o_valid}, 512'd0);
    put_word(32'h0101_0010, 0);
    chk_val("bad1_err", {511'd0, o_err}, 512'd1);
    chk_val("bad1_valid", {511'd0, o_valid}, 512'd0);
    @(posedge clk);
    #1;
    chk_val("bad1_errdrop", {511'd0, o_err}, 512'd0);
    fill_rand();
    load_frame(16, 16, 0);
    check_out("good", 16, 16);
    finish_hs("good", 16);

    // Random gaps over 20 frames
    for (int f = 0; f < 20; f++) begin
      rl = $urandom_range(REF_MAX, 1);
      dl = $urandom_range(READ_MAX, 1);
      fill_rand();
      load_frame(rl, dl, 3);
      check_out("gap", rl, dl);
      finish_hs("gap", rl);
    end

    // Reset mid-load
    fill_rand();
    put_word({16'd64, 16'd32}, 0);
    for (int k = 0; k < 3; k++) put_word(ref_w[k], 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_val("mrst_ref", o_sequence_ref, 512'd0);
    chk_val("mrst_read", {256'd0, o_sequence_read}, 512'd0);
    chk_val("mrst_len", {495'd0, o_seq_ref_length, o_seq_read_length}, 512'd0);
    chk_val("mrst_wready", {511'd0, o_word_ready}, 512'd1);
    chk_val("mrst_valid", {511'd0, o_valid}, 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    load_frame(40, 24, 0);
    check_out("post", 40, 24);
    finish_hs("post", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sw_seq_loader.md
# sw_seq_loader

Upstream feeder for `SW_core`: it accepts a framed 32-bit word stream from the host, one header word followed by packed 2-bit bases. It assembles the reference and read sequences into left-aligned, zero-padded vectors with 1-based lengths. It then presents them to `SW_core` through a valid/ready handshake. The block sits between the host/bus interface and the systolic Smith-Waterman core and replaces testbench-driven stimulus in the integrated design.

## Interface
Parameters:
- `REF_MAX_LENGTH`, 256: maximum reference bases; multiple of 16.
- `READ_MAX_LENGTH`, 128: maximum read bases; multiple of 16.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.

Host word stream:
- `i_word`  in  32  header or packed bases.
- `i_word_valid`  in  1  `i_word` is valid.
- `o_word_ready`  out  1  the loader accepts the word this cycle.

Core side:
- `o_valid`  out  1  the sequence pair is presented.
- `i_ready`  in  1  the core accepts; wired to `SW_core.o_ready`.
- `o_sequence_ref`  out  2*`REF_MAX_LENGTH`  reference bases; first base in the MSBs.
- `o_sequence_read`  out  2*`READ_MAX_LENGTH`  read bases; first base in the MSBs.
- `o_seq_ref_length`  out  $clog2(`REF_MAX_LENGTH`)+1  reference length, 1-based.
- `o_seq_read_length`  out  $clog2(`READ_MAX_LENGTH`)+1  read length, 1-based.

Status:
- `o_err`  out  1  one-cycle pulse when a header is rejected.

## Operation
- Frame format:
  - Header: `[31:16]` = ref_len, `[15:0]` = read_len.
  - Then ceil(ref_len/16) ref words, then ceil(read_len/16) read words.
  - Each word holds 16 bases; the first base is in `[31:30]`.
- Word transfer: a word transfers when `i_word_valid && o_word_ready`. `o_word_ready` = 1 in IDLE, LOAD_REF and LOAD_READ; it is 0 in SEND.
- Packing: word k of the ref payload is written to `o_sequence_ref[2*REF_MAX_LENGTH-1-32k -: 32]`. The read payload is packed the same way into `o_sequence_read`.
- Tail masking: in the last word of each sequence, bit pairs for base index ≥ length are forced to 0. All bits beyond the payload are 0, so the padding matches `SW_core` expectations.
- FSM:
  - IDLE: on a header transfer, check 1 ≤ ref_len ≤ `REF_MAX_LENGTH` and 1 ≤ read_len ≤ `READ_MAX_LENGTH`.
    - Valid header: latch the lengths, clear both sequence registers and the word counter, and go to LOAD_REF.
    - Invalid header: pulse `o_err` on the next cycle and stay in IDLE. The next word is treated as a new header.
  - LOAD_REF: on each transfer, store the word and increment the counter. On the last ref word, clear the counter and go to LOAD_READ.
  - LOAD_READ: same as LOAD_REF. On the last read word, go to SEND.
  - SEND: `o_valid` = 1. On `o_valid && i_ready`, go to IDLE.
- Output hold: while `o_valid` = 1, `o_sequence_*` and `o_seq_*_length` are held stable. They stay unchanged after the handshake until the next valid header arrives.
- Gaps: `i_word_valid` may drop at any point in a frame; state and counter hold.
- Reset values (any time, including mid-frame): state IDLE; `o_valid` = 0, `o_err` = 0, `o_word_ready` = 1; sequences, lengths and counter = 0. A partial frame is discarded.

## Timing
- All outputs are registered, except `o_word_ready`, which is decoded from the state register.
- If the last read word transfers at edge N, `o_valid` is 1 from edge N onward (visible during cycle N+1).
- The earliest handshake is in that same cycle. The next header is accepted from the cycle after the handshake, so there is one dead cycle per frame.
- `o_err` rises at the edge that consumes the bad header and lasts 1 cycle.
- Minimum frame time: 1 + ceil(ref_len/16) + ceil(read_len/16) word cycles, plus 1 SEND cycle.
- `i_ready` low in SEND: `o_valid` stays 1 indefinitely. There is no timeout.

## Test plan
- Full-length frame: header 0x00800080, 8 ref + 8 read words, `i_ready` = 1.
  - `o_valid` pulses for exactly 1 cycle, 1 cycle after the last word.
  - `o_sequence_ref[511:256]` = ref payload, `[255:0]` = 0.
  - Lengths = 128/128.
- Short lengths with masking: header 0x00140005 (20/5), all-ones payload words.
  - Ref `[511:472]` = 1s, rest 0.
  - Read `[255:246]` = 1s, rest 0.
- Core backpressure: `i_ready` held 0 for 10 cycles in SEND.
  - `o_valid` stays 1, outputs are stable, `o_word_ready` = 0.
  - Handshake occurs on the cycle `i_ready` rises; IDLE follows.
- Bad header: 0x00000010, then 0x01010010 (ref_len 257 > 256), then a valid 0x00100010 frame.
  - Two `o_err` pulses, no `o_valid` for the bad headers.
  - The third frame delivers correctly.
- Valid gaps: `i_word_valid` toggles with a random 0–3 cycle gap per word over 20 frames.
  - Outputs match a reference model; the `SW_core` score, row and column match `pattern_ans.txt`.
- Reset mid-load: assert `rst_n` = 0 after 3 ref words.
  - All outputs reset asynchronously.
  - After release, a fresh frame is delivered with no residue from the aborted frame.
